alu_unit: RTL and testbench
===========================

# alu_unit

Integer execution unit on the receiving end of the reservation-station dispatch port, and the producer of the ALU channel of the common data bus. It accepts at most one dispatched operation per cycle and computes the result. Results are broadcast on `cdb_alu_*` exactly once each, so the RS, ROB and LSB can wake dependants. A small result FIFO absorbs collisions with an optional iterative multiplier. A stall output throttles the RS.

## Interface
Parameters:
- `RES_DEPTH`, default 4 — result FIFO entries; power of two, ≥ 4.
- `ROB_BIT`, default 4 — ROB index width; index 0 is reserved ("no dependency", never broadcast).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global ready; low freezes all state.
- `alu_rb`  in  1  rollback flush, synchronous.
- `alu_full`  out  1  stall request, fed to the RS `rs_st` input.
- `alu_ena`  in  1  dispatch valid.
- `alu_opt`  in  `INST_OPT_TP`  operation code.
- `alu_val1`  in  32  operand 1 (rs1).
- `alu_val2`  in  32  operand 2: rs2 for R-type/branch; PC for JAL/JALR/AUIPC.
- `alu_imm`  in  32  sign-extended immediate.
- `alu_rob_idx`  in  ROB_BIT  destination ROB entry.
- `cdb_alu_valid`  out  1  broadcast valid.
- `cdb_alu_src`  out  ROB_BIT  ROB entry being completed.
- `cdb_alu_val`  out  32  result value.
- `cdb_alu_jump`  out  1  control transfer taken.
- `cdb_alu_tgt`  out  32  jump target; 0 for non-JAL/JALR.

## Operation
- R/I arithmetic: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND use val1 op val2. The I-forms use val1 op imm.
- Shift amounts use only bits [4:0]. SLT is signed; SLTU is unsigned. All arithmetic is modulo 2^32.
- LUI: val=imm.
- AUIPC: val=val2+imm.
- JAL: val=val2+4, jump=1, tgt=val2+imm.
- JALR: val=val2+4, jump=1, tgt=(val1+imm)&~1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: val=jump=taken, tgt=0. The ROB computes the branch target.
- Stores/loads/OPT_NONE never arrive here; if one does, broadcast val=0.
- CDB output register is loaded each edge by priority:
  - multiplier completion, else
  - FIFO head, else
  - incoming simple op, bypassing the FIFO only when the FIFO is empty.
- A simple op that cannot take the CDB slot is pushed to the FIFO tail.
- `alu_full` = (FIFO count ≥ RES_DEPTH−2) OR multiplier not IDLE. One skid dispatch arriving the cycle after `alu_full` rises must still be accepted.
- FIFO push when full is a design error; the bench asserts it never occurs.
- `alu_rb`: clear FIFO pointers and count, return the multiplier to IDLE, clear `cdb_alu_valid`. A dispatch in the same cycle is dropped.
- `rdy` low: no register changes. CDB outputs hold their values and are rebroadcast when `rdy` returns.

## Timing
- Reset: `cdb_alu_valid`=0, `cdb_alu_src`=0, `cdb_alu_val`=0, `cdb_alu_jump`=0, `cdb_alu_tgt`=0; FIFO empty; multiplier IDLE; `alu_full`=0.
- `cdb_alu_valid` is high for exactly one cycle per result and deasserts the next edge unless a new result loads.
- Simple-op latency: `alu_ena` sampled at edge k → CDB valid in the cycle after edge k when the FIFO is empty and no multiplier completion is pending. Otherwise it is delayed one cycle per older queued result.
- Multiplier FSM: IDLE → RUN (5-bit counter, 32 shift-add iterations) → DONE.
  - Accept at edge k; RUN at edges k+1..k+32; DONE at edge k+32.
  - Broadcast loads at edge k+33, then IDLE.
- `alu_rb` has priority over `rdy` and dispatch. `rst_n` has priority over everything.

## Configuration
- `ALU_MUL_EN` defined: MUL/MULH/MULHSU/MULHU are executed by the iterative multiplier. MUL returns low 32 bits; the MULH variants return the high 32 bits with the signedness the opcode names.
- `ALU_MUL_EN` undefined: no multiplier logic. MUL opcodes are treated as simple ops returning val=0, and `alu_full` depends only on FIFO count.

## Structure
- `utils.v` holds `WORD_TP`, `ROB_IDX_TP`, `ZERO_ROB_IDX`, all `OPT_*` codes including `OPT_MUL*`, `TRUE`/`FALSE`.
- Sub-module `alu_mul_iter`:
  - owns the IDLE/RUN/DONE FSM, counter and 64-bit accumulator;
  - ports: start, signedness, operands, result, done, flush;
  - compiled only under `ALU_MUL_EN`.

## Test plan
- Reset with `rst_n`=0 mid-traffic → all CDB outputs 0 and `alu_full`=0 immediately, asynchronously.
- ADDI val1=0xFFFFFFFF, imm=1, rob 3 → one cycle later valid=1, src=3, val=0x00000000, for exactly one cycle.
- JALR val1=0x1003, imm=4, val2(PC)=0x200, rob 5 → val=0x204, jump=1, tgt=0x1006. BLTU 1 vs 0xFFFFFFFF → val=1, jump=1.
- Back-to-back dispatches of 4 ADDs → 4 consecutive broadcasts in order with src 1,2,3,4; `alu_full` never rises.
- `ALU_MUL_EN`: MULHU 0xFFFFFFFF×0xFFFFFFFF accepted at edge k, skid ADD at k+1 → ADD broadcast after k+1, `alu_full`=1 until IDLE, MULHU val=0xFFFFFFFE loaded at edge k+33.
- Multiplier in RUN plus 2 queued results, then `alu_rb`=1 → next cycle `cdb_alu_valid`=0, FIFO empty, no later broadcast of the flushed ops.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared opcode encoding, multiplier FSM states and helpers for the alu_unit execution slice.
package alu_unit_pkg;

  localparam int OPT_W = 6;

  typedef enum logic [OPT_W-1:0] {
    OPT_NONE,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI, OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU, OPT_SB, OPT_SH, OPT_SW,
    OPT_MUL, OPT_MULH, OPT_MULHSU, OPT_MULHU
  } inst_opt_e;

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  function automatic logic isMulOpt(inst_opt_e opt);
    return opt inside {OPT_MUL, OPT_MULH, OPT_MULHSU, OPT_MULHU};
  endfunction

  function automatic logic isImmOpt(inst_opt_e opt);
    return opt inside {OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
                       OPT_SLLI, OPT_SRLI, OPT_SRAI};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative 32x32 shift-add multiplier (IDLE/RUN/DONE); only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy_i,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic        aSigned_i,
  input  logic        bSigned_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  mul_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic        neg_q;
  logic [31:0] aMag, bMag;
  logic [32:0] partial;

  // Multiply magnitudes unsigned and fix the sign once at the end.
  assign aMag    = (aSigned_i && a_i[31]) ? -a_i : a_i;
  assign bMag    = (bSigned_i && b_i[31]) ? -b_i : b_i;
  assign partial = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= MUL_IDLE;
    end else if (rdy_i) begin
      unique case (state_q)
        MUL_IDLE: if (start_i) begin
          state_q <= MUL_RUN;
          cnt_q   <= '0;
          acc_q   <= {32'd0, bMag};
          mcand_q <= aMag;
          neg_q   <= (aSigned_i && a_i[31]) ^ (bSigned_i && b_i[31]);
        end
        MUL_RUN: begin
          acc_q <= {partial, acc_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= MUL_DONE;
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != MUL_IDLE);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = neg_q ? -acc_q : acc_q;

endmodule
`endif

// File: rtl/alu_unit.sv
// Integer ALU feeding the CDB ALU channel, with a small result FIFO.
// Define ALU_MUL_EN to execute MUL/MULH/MULHSU/MULHU on the iterative multiplier.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int RES_DEPTH = 4,
  parameter int ROB_BIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy_i,
  input  logic               alu_rb_i,
  output logic               alu_full_o,
  input  logic               alu_ena_i,
  input  logic [OPT_W-1:0]   alu_opt_i,
  input  logic [31:0]        alu_val1_i,
  input  logic [31:0]        alu_val2_i,
  input  logic [31:0]        alu_imm_i,
  input  logic [ROB_BIT-1:0] alu_rob_idx_i,
  output logic               cdb_alu_valid_o,
  output logic [ROB_BIT-1:0] cdb_alu_src_o,
  output logic [31:0]        cdb_alu_val_o,
  output logic               cdb_alu_jump_o,
  output logic [31:0]        cdb_alu_tgt_o
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(RES_DEPTH - 2);

  typedef struct packed {
    logic [ROB_BIT-1:0] src;
    logic [31:0]        val;
    logic               jump;
    logic [31:0]        tgt;
  } res_t;

  inst_opt_e        opt;
  logic             accept, isMulOp, simpleIn, push, pop;
  logic             mulBusy, mulDone;
  logic [31:0]      opB;
  logic             taken;
  res_t             simpleRes, mulRes;
  res_t             cdb_q, cdb_d;
  logic             cdbValid_q, cdbValid_d;
  res_t             fifo_q [RES_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  assign opt      = inst_opt_e'(alu_opt_i);
  assign accept   = alu_ena_i && rdy_i && !alu_rb_i;
  assign simpleIn = accept && !isMulOp;
  assign opB      = isImmOpt(opt) ? alu_imm_i : alu_val2_i;

  always_comb begin
    simpleRes     = '0;
    simpleRes.src = alu_rob_idx_i;
    taken         = 1'b0;
    case (opt)
      OPT_ADD, OPT_ADDI:   simpleRes.val = alu_val1_i + opB;
      OPT_SUB:             simpleRes.val = alu_val1_i - opB;
      OPT_SLL, OPT_SLLI:   simpleRes.val = alu_val1_i << opB[4:0];
      OPT_SLT, OPT_SLTI:   simpleRes.val = {31'd0, $signed(alu_val1_i) < $signed(opB)};
      OPT_SLTU, OPT_SLTIU: simpleRes.val = {31'd0, alu_val1_i < opB};
      OPT_XOR, OPT_XORI:   simpleRes.val = alu_val1_i ^ opB;
      OPT_SRL, OPT_SRLI:   simpleRes.val = alu_val1_i >> opB[4:0];
      OPT_SRA, OPT_SRAI:   simpleRes.val = $signed(alu_val1_i) >>> opB[4:0];
      OPT_OR, OPT_ORI:     simpleRes.val = alu_val1_i | opB;
      OPT_AND, OPT_ANDI:   simpleRes.val = alu_val1_i & opB;
      OPT_LUI:             simpleRes.val = alu_imm_i;
      OPT_AUIPC:           simpleRes.val = alu_val2_i + alu_imm_i;
      OPT_JAL: begin
        simpleRes.val  = alu_val2_i + 32'd4;
        simpleRes.jump = 1'b1;
        simpleRes.tgt  = alu_val2_i + alu_imm_i;
      end
      OPT_JALR: begin
        simpleRes.val  = alu_val2_i + 32'd4;
        simpleRes.jump = 1'b1;
        simpleRes.tgt  = (alu_val1_i + alu_imm_i) & ~32'd1;
      end
      OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU: begin
        case (opt)
          OPT_BEQ:  taken = (alu_val1_i == alu_val2_i);
          OPT_BNE:  taken = (alu_val1_i != alu_val2_i);
          OPT_BLT:  taken = ($signed(alu_val1_i) <  $signed(alu_val2_i));
          OPT_BGE:  taken = ($signed(alu_val1_i) >= $signed(alu_val2_i));
          OPT_BLTU: taken = (alu_val1_i <  alu_val2_i);
          default:  taken = (alu_val1_i >= alu_val2_i);
        endcase
        simpleRes.val  = {31'd0, taken};
        simpleRes.jump = taken;
      end
      default: simpleRes.val = 32'd0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [ROB_BIT-1:0] mulSrc_q;
  logic               mulHigh_q;
  logic [63:0]        product;

  assign isMulOp = isMulOpt(opt);

  alu_mul_iter uMul (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy_i     (rdy_i),
    .flush_i   (alu_rb_i),
    .start_i   (accept && isMulOp),
    .aSigned_i (opt inside {OPT_MULH, OPT_MULHSU}),
    .bSigned_i (opt == OPT_MULH),
    .a_i       (alu_val1_i),
    .b_i       (alu_val2_i),
    .busy_o    (mulBusy),
    .done_o    (mulDone),
    .product_o (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulSrc_q  <= '0;
      mulHigh_q <= 1'b0;
    end else if (accept && isMulOp && !mulBusy) begin
      mulSrc_q  <= alu_rob_idx_i;
      mulHigh_q <= (opt != OPT_MUL);
    end
  end

  always_comb begin
    mulRes     = '0;
    mulRes.src = mulSrc_q;
    mulRes.val = mulHigh_q ? product[63:32] : product[31:0];
  end
`else
  assign isMulOp = 1'b0;
  assign mulBusy = 1'b0;
  assign mulDone = 1'b0;
  assign mulRes  = '0;
`endif

  // CDB slot priority: multiplier completion, then FIFO head, then a bypassing new op.
  always_comb begin
    cdb_d      = cdb_q;
    cdbValid_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (mulDone) begin
      cdb_d      = mulRes;
      cdbValid_d = 1'b1;
      push       = simpleIn;
    end else if (count_q != '0) begin
      cdb_d      = fifo_q[head_q];
      cdbValid_d = 1'b1;
      pop        = 1'b1;
      push       = simpleIn;
    end else if (simpleIn) begin
      cdb_d      = simpleRes;
      cdbValid_d = 1'b1;
    end
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q      <= '0;
      cdbValid_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (alu_rb_i) begin
      cdbValid_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (rdy_i) begin
      cdb_q      <= cdb_d;
      cdbValid_q <= cdbValid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_i && !alu_rb_i && push) fifo_q[tail_q] <= simpleRes;
  end

  assign alu_full_o      = (count_q >= FULL_LVL) || mulBusy;
  assign cdb_alu_valid_o = cdbValid_q;
  assign cdb_alu_src_o   = cdb_q.src;
  assign cdb_alu_val_o   = cdb_q.val;
  assign cdb_alu_jump_o  = cdb_q.jump;
  assign cdb_alu_tgt_o   = cdb_q.tgt;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized traffic scored by ROB index.
// Multiplier cases are included when ALU_MUL_EN is defined.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, rdy, aluRb, aluFull, aluEna;
  logic [OPT_W-1:0]  aluOpt;
  logic [31:0]       val1, val2, imm;
  logic [3:0]        robIdx;
  logic              cdbValid, cdbJump;
  logic [3:0]        cdbSrc;
  logic [31:0]       cdbVal, cdbTgt;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] val;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  exp_t expTab [16];
  logic pending [16];
  logic mulOutstanding = 1'b0;
  logic [3:0] mulRob = '0;

  alu_unit #(.RES_DEPTH(4), .ROB_BIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy_i           (rdy),
    .alu_rb_i        (aluRb),
    .alu_full_o      (aluFull),
    .alu_ena_i       (aluEna),
    .alu_opt_i       (aluOpt),
    .alu_val1_i      (val1),
    .alu_val2_i      (val2),
    .alu_imm_i       (imm),
    .alu_rob_idx_i   (robIdx),
    .cdb_alu_valid_o (cdbValid),
    .cdb_alu_src_o   (cdbSrc),
    .cdb_alu_val_o   (cdbVal),
    .cdb_alu_jump_o  (cdbJump),
    .cdb_alu_tgt_o   (cdbTgt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input inst_opt_e op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] i, input logic [3:0] rob);
    aluEna = 1'b1;
    aluOpt = op;
    val1   = a;
    val2   = b;
    imm    = i;
    robIdx = rob;
  endtask

  task automatic clearStimulus();
    aluEna = 1'b0;
    aluOpt = '0;
    val1   = '0;
    val2   = '0;
    imm    = '0;
    robIdx = '0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, cdbValid, 0);
    checkOutput({tag, "_src"},   cdbSrc,   0);
    checkOutput({tag, "_val"},   cdbVal,   0);
    checkOutput({tag, "_jump"},  cdbJump,  0);
    checkOutput({tag, "_tgt"},   cdbTgt,   0);
    checkOutput({tag, "_full"},  aluFull,  0);
  endtask

  // Reference: instruction semantics in plain integer arithmetic.
  function automatic exp_t refModel(inst_opt_e op, logic [31:0] a, logic [31:0] b, logic [31:0] i);
    exp_t  r;
    longint p;
    r.val = '0; r.jump = 1'b0; r.tgt = '0; p = 0;
    case (op)
      OPT_ADD:   r.val = a + b;
      OPT_ADDI:  r.val = a + i;
      OPT_SUB:   r.val = a - b;
      OPT_SLL:   r.val = a << b[4:0];
      OPT_SLLI:  r.val = a << i[4:0];
      OPT_SLT:   r.val = (int'(a) < int'(b)) ? 1 : 0;
      OPT_SLTI:  r.val = (int'(a) < int'(i)) ? 1 : 0;
      OPT_SLTU:  r.val = (a < b) ? 1 : 0;
      OPT_SLTIU: r.val = (a < i) ? 1 : 0;
      OPT_XOR:   r.val = a ^ b;
      OPT_XORI:  r.val = a ^ i;
      OPT_SRL:   r.val = a >> b[4:0];
      OPT_SRLI:  r.val = a >> i[4:0];
      OPT_SRA:   r.val = int'(a) >>> b[4:0];
      OPT_SRAI:  r.val = int'(a) >>> i[4:0];
      OPT_OR:    r.val = a | b;
      OPT_ORI:   r.val = a | i;
      OPT_AND:   r.val = a & b;
      OPT_ANDI:  r.val = a & i;
      OPT_LUI:   r.val = i;
      OPT_AUIPC: r.val = b + i;
      OPT_JAL:   begin r.val = b + 4; r.jump = 1'b1; r.tgt = b + i; end
      OPT_JALR:  begin r.val = b + 4; r.jump = 1'b1; r.tgt = (a + i) & 32'hFFFF_FFFE; end
      OPT_BEQ:   r.jump = (a == b);
      OPT_BNE:   r.jump = (a != b);
      OPT_BLT:   r.jump = (int'(a) < int'(b));
      OPT_BGE:   r.jump = (int'(a) >= int'(b));
      OPT_BLTU:  r.jump = (a < b);
      OPT_BGEU:  r.jump = (a >= b);
`ifdef ALU_MUL_EN
      OPT_MUL:    r.val = a * b;
      OPT_MULH:   begin p = longint'(int'(a)) * longint'(int'(b));        r.val = p[63:32]; end
      OPT_MULHSU: begin p = longint'(int'(a)) * longint'({32'd0, b});     r.val = p[63:32]; end
      OPT_MULHU:  begin p = longint'({32'd0, a}) * longint'({32'd0, b}); r.val = p[63:32]; end
`endif
      default: r.val = '0;
    endcase
    if (op inside {OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU}) r.val = {31'd0, r.jump};
    return r;
  endfunction

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic scoreBroadcast();
    checkOutput("sb_pending", pending[cdbSrc], 1);
    checkOutput("sb_val",  cdbVal,  expTab[cdbSrc].val);
    checkOutput("sb_jump", cdbJump, expTab[cdbSrc].jump);
    checkOutput("sb_tgt",  cdbTgt,  expTab[cdbSrc].tgt);
    pending[cdbSrc] = 1'b0;
    if (mulOutstanding && cdbSrc == mulRob) mulOutstanding = 1'b0;
  endtask

  initial begin
    inst_opt_e  op;
    logic [31:0] a, b, i;
    logic [3:0]  nextRob;
    logic        fullPrev;
    int          leftover, stray;

    for (int k = 0; k < 16; k++) pending[k] = 1'b0;
    rst_n = 1'b0; rdy = 1'b1; aluRb = 1'b0;
    clearStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
    stepCycle();

    // ADDI wraps to zero, broadcast for exactly one cycle.
    applyStimulus(OPT_ADDI, 32'hFFFF_FFFF, 32'h0, 32'h1, 4'd3);
    stepCycle();
    clearStimulus();
    checkOutput("addi_valid", cdbValid, 1);
    checkOutput("addi_src",   cdbSrc,   3);
    checkOutput("addi_val",   cdbVal,   0);
    stepCycle();
    checkOutput("addi_onecycle", cdbValid, 0);

    applyStimulus(OPT_JALR, 32'h1003, 32'h200, 32'h4, 4'd5);
    stepCycle();
    applyStimulus(OPT_BLTU, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'd6);
    checkOutput("jalr_src",  cdbSrc,  5);
    checkOutput("jalr_val",  cdbVal,  32'h204);
    checkOutput("jalr_jump", cdbJump, 1);
    checkOutput("jalr_tgt",  cdbTgt,  32'h1006);
    stepCycle();
    clearStimulus();
    checkOutput("bltu_valid", cdbValid, 1);
    checkOutput("bltu_val",   cdbVal,   1);
    checkOutput("bltu_jump",  cdbJump,  1);
    checkOutput("bltu_tgt",   cdbTgt,   0);
    stepCycle();

    // Back-to-back ADDs stream out in order with no stall.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(OPT_ADD, 32'(n * 10), 32'd7, 32'h0, 4'(n + 1));
      stepCycle();
      checkOutput("b2b_valid", cdbValid, 1);
      checkOutput("b2b_src",   cdbSrc,   n + 1);
      checkOutput("b2b_val",   cdbVal,   n * 10 + 7);
      checkOutput("b2b_full",  aluFull,  0);
    end
    clearStimulus();
    stepCycle();
    checkOutput("b2b_end", cdbValid, 0);

    // rdy low holds the broadcast registers.
    applyStimulus(OPT_SUB, 32'd100, 32'd1, 32'h0, 4'd9);
    stepCycle();
    clearStimulus();
    rdy = 1'b0;
    stepCycle();
    checkOutput("rdy_hold_valid", cdbValid, 1);
    checkOutput("rdy_hold_src",   cdbSrc,   9);
    checkOutput("rdy_hold_val",   cdbVal,   99);
    rdy = 1'b1;
    stepCycle();
    checkOutput("rdy_release", cdbValid, 0);

    // Rollback clears valid and drops the same-cycle dispatch.
    applyStimulus(OPT_ADD, 32'd1, 32'd1, 32'h0, 4'd7);
    stepCycle();
    applyStimulus(OPT_ADD, 32'd2, 32'd2, 32'h0, 4'd8);
    aluRb = 1'b1;
    stepCycle();
    aluRb = 1'b0;
    clearStimulus();
    checkOutput("rb_valid", cdbValid, 0);
    stray = 0;
    for (int n = 0; n < 5; n++) begin
      stepCycle();
      if (cdbValid) stray++;
    end
    checkOutput("rb_no_stray", stray, 0);

`ifdef ALU_MUL_EN
    begin
      int  edges;
      logic got, fullDrop;
      applyStimulus(OPT_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd11);
      stepCycle();
      applyStimulus(OPT_ADD, 32'd5, 32'd6, 32'h0, 4'd12);
      stepCycle();
      clearStimulus();
      checkOutput("skid_valid", cdbValid, 1);
      checkOutput("skid_src",   cdbSrc,   12);
      checkOutput("skid_val",   cdbVal,   11);
      checkOutput("mul_full",   aluFull,  1);
      got = 1'b0; fullDrop = 1'b0; edges = 0;
      for (int n = 2; n <= 40 && !got; n++) begin
        stepCycle();
        if (cdbValid) begin got = 1'b1; edges = n; end
        else if (!aluFull) fullDrop = 1'b1;
      end
      checkOutput("mul_latency",  edges,    33);
      checkOutput("mul_src",      cdbSrc,   11);
      checkOutput("mul_val",      cdbVal,   32'hFFFF_FFFE);
      checkOutput("mul_fullheld", fullDrop, 0);
      stepCycle();
      checkOutput("mul_idle_full", aluFull, 0);

      applyStimulus(OPT_MUL, 32'd3, 32'd4, 32'h0, 4'd13);
      stepCycle();
      clearStimulus();
      repeat (3) stepCycle();
      aluRb = 1'b1;
      stepCycle();
      aluRb = 1'b0;
      checkOutput("mulrb_valid", cdbValid, 0);
      checkOutput("mulrb_full",  aluFull,  0);
      stray = 0;
      for (int n = 0; n < 40; n++) begin
        stepCycle();
        if (cdbValid) stray++;
      end
      checkOutput("mulrb_no_stray", stray, 0);
    end
`endif

    // Randomized traffic; the RS model reacts to alu_full one cycle late (skid).
    nextRob = 4'd1;
    fullPrev = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (rdy && cdbValid) scoreBroadcast();
      rdy = ($urandom_range(0, 9) != 0);
      clearStimulus();
      if (rdy && !fullPrev && $urandom_range(0, 3) != 0 && !pending[nextRob]) begin
        op = inst_opt_e'($urandom_range(0, int'(OPT_MULHU)));
`ifdef ALU_MUL_EN
        if (isMulOpt(op) && mulOutstanding) op = OPT_ADD;
        if (isMulOpt(op)) begin mulOutstanding = 1'b1; mulRob = nextRob; end
`endif
        a = randWord(); b = randWord(); i = randWord();
        applyStimulus(op, a, b, i, nextRob);
        expTab[nextRob] = refModel(op, a, b, i);
        pending[nextRob] = 1'b1;
        nextRob = (nextRob == 4'd15) ? 4'd1 : nextRob + 4'd1;
      end
      fullPrev = aluFull;
      stepCycle();
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (rdy && cdbValid) scoreBroadcast();
      rdy = 1'b1;
      clearStimulus();
      stepCycle();
    end
    leftover = 0;
    for (int k = 0; k < 16; k++) if (pending[k]) leftover++;
    checkOutput("drain_pending", leftover, 0);

    // Asynchronous reset in the middle of a broadcast.
    applyStimulus(OPT_LUI, 32'h0, 32'h0, 32'hABCD_E000, 4'd2);
    stepCycle();
    applyStimulus(OPT_JAL, 32'h0, 32'h100, 32'h40, 4'd4);
    checkOutput("pre_reset_valid", cdbValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    clearStimulus();
    stepCycle();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
